// File: rtl/memstage_pkg.sv
// memstage_pkg: shared types and helpers for the memory-access stage.
//   mem_size_t    : access width encoding (BYTE/HALF/WORD/DOUBLE)
//   state_t       : memstage FSM states (IDLE/REQ/RESP)
//   size_mask     : byte-strobe pattern for an access width at lane 0
//   is_misaligned : natural-alignment check on the low address bits
package memstage_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [7:0] size_mask(input mem_size_t size);
        logic [7:0] mask;
        case (size)
            BYTE:    mask = 8'h01;
            HALF:    mask = 8'h03;
            WORD:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Only the low three address bits matter for natural alignment.
    function automatic logic is_misaligned(input logic [2:0] addr, input mem_size_t size);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = addr[0];
            WORD:    bad = |addr[1:0];
            default: bad = |addr[2:0];
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memstage_load_align.sv
// load_align: extracts a load result from an aligned 64-bit read doubleword.
// Ports:
//   rdata       in  64  doubleword returned by data memory
//   offset      in  3   byte offset of the access within the doubleword
//   size        in  2   access width (mem_size_t)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   value       out 64  extended load value
module load_align
    import memstage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [63:0] value
);

    logic [63:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        value = '0;
        case (size)
            BYTE:    value = is_unsigned ? {56'b0, shifted[7:0]}
                                         : {{56{shifted[7]}}, shifted[7:0]};
            HALF:    value = is_unsigned ? {48'b0, shifted[15:0]}
                                         : {{48{shifted[15]}}, shifted[15:0]};
            WORD:    value = is_unsigned ? {32'b0, shifted[31:0]}
                                         : {{32{shifted[31]}}, shifted[31:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/memstage.sv
// memstage: memory-access stage of the five-stage RISC-V pipeline.
// ALU results pass through to write-back in one cycle; loads/stores are
// issued on the data-memory port with byte-lane alignment and the stage
// stalls execute while an access is outstanding.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   EXMEM_ready             execute output valid this cycle
//   exmm_aluresult          ALU result or effective address
//   dest_reg                destination register
//   mem_active/load         memory op / load (1) vs store (0)
//   mem_size/mem_unsigned   access width / zero-extend loads
//   store_data              rs2 value for stores
//   dmem_req/we/addr/wdata/wstrb   data-memory request (out)
//   dmem_gnt/rvalid/rdata          data-memory grant and read response (in)
//   MEMEX_stall             execute must hold (state != IDLE)
//   MEMEX_rd/MEMEX_rdval    forwarding pair, mirrors write-back
//   MEMWB_ready/rd/val      registered write-back result
//   misalign                one-cycle misaligned-access pulse
//
// Handshakes: execute presents an op with EXMEM_ready and holds it while
// MEMEX_stall is high; the op is taken only on an IDLE edge. A memory
// request is offered with dmem_req and its fields held stable until the
// edge where dmem_gnt is high; read data is taken on the edge where
// dmem_rvalid is high (in RESP, or in REQ together with the grant).
// Grant/response strobes seen in IDLE are ignored.
module memstage
    import memstage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        EXMEM_ready,
    input  logic [63:0] exmm_aluresult,
    input  logic [5:0]  dest_reg,
    input  logic        mem_active,
    input  logic        load,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [63:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        MEMEX_stall,
    output logic [5:0]  MEMEX_rd,
    output logic [63:0] MEMEX_rdval,
    output logic        MEMWB_ready,
    output logic [5:0]  MEMWB_rd,
    output logic [63:0] MEMWB_val,
    output logic        misalign
);

    state_t      state;
    logic [63:0] addr_q;
    logic [63:0] sdata_q;
    mem_size_t   size_q;
    logic        uns_q;
    logic        load_q;
    logic [5:0]  rd_q;

    logic        wb_ready_q;
    logic [5:0]  wb_rd_q;
    logic [63:0] wb_val_q;
    logic        mis_q;

    logic        in_req;
    logic [63:0] load_value;
    mem_size_t   size_in;

    assign size_in = mem_size_t'(mem_size);
    assign in_req  = (state == REQ);

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .value       (load_value)
    );

    // Request fields come straight from the latched op, so they are stable
    // for the whole REQ state; they read as zero outside REQ.
    assign dmem_req   = in_req;
    assign dmem_we    = in_req & ~load_q;
    assign dmem_addr  = in_req ? {addr_q[63:3], 3'b000} : '0;
    assign dmem_wstrb = (in_req && !load_q) ? (size_mask(size_q) << addr_q[2:0]) : '0;
    assign dmem_wdata = (in_req && !load_q) ? (sdata_q << {addr_q[2:0], 3'b000}) : '0;

    assign MEMEX_stall = (state != IDLE);
    assign MEMWB_ready = wb_ready_q;
    assign MEMWB_rd    = wb_rd_q;
    assign MEMWB_val   = wb_val_q;
    assign MEMEX_rd    = wb_rd_q;
    assign MEMEX_rdval = wb_val_q;
    assign misalign    = mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            sdata_q    <= '0;
            size_q     <= BYTE;
            uns_q      <= 1'b0;
            load_q     <= 1'b0;
            rd_q       <= '0;
            wb_ready_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
            mis_q      <= 1'b0;
        end else begin
            // Every cycle that does not complete an op writes back a bubble.
            wb_ready_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_val_q   <= '0;
            mis_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (EXMEM_ready) begin
                        if (!mem_active) begin
                            wb_ready_q <= 1'b1;
                            wb_rd_q    <= dest_reg;
                            wb_val_q   <= exmm_aluresult;
                        end else if (is_misaligned(exmm_aluresult[2:0], size_in)) begin
                            mis_q <= 1'b1;
                        end else begin
                            addr_q  <= exmm_aluresult;
                            sdata_q <= store_data;
                            size_q  <= size_in;
                            uns_q   <= mem_unsigned;
                            load_q  <= load;
                            rd_q    <= dest_reg;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        if (!load_q) begin
                            // Store retires with no register write (rd = x0).
                            wb_ready_q <= 1'b1;
                            state      <= IDLE;
                        end else if (dmem_rvalid) begin
                            wb_ready_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_val_q   <= load_value;
                            state      <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_ready_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_val_q   <= load_value;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memstage.sv
// tb_memstage: table-driven bench for memstage with an expected-result queue.
module tb_memstage;

    logic        clk;
    logic        reset;
    logic        EXMEM_ready;
    logic [63:0] exmm_aluresult;
    logic [5:0]  dest_reg;
    logic        mem_active;
    logic        load;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [63:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        MEMEX_stall;
    logic [5:0]  MEMEX_rd;
    logic [63:0] MEMEX_rdval;
    logic        MEMWB_ready;
    logic [5:0]  MEMWB_rd;
    logic [63:0] MEMWB_val;
    logic        misalign;

    memstage dut (
        .clk            (clk),
        .reset          (reset),
        .EXMEM_ready    (EXMEM_ready),
        .exmm_aluresult (exmm_aluresult),
        .dest_reg       (dest_reg),
        .mem_active     (mem_active),
        .load           (load),
        .mem_size       (mem_size),
        .mem_unsigned   (mem_unsigned),
        .store_data     (store_data),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .MEMEX_stall    (MEMEX_stall),
        .MEMEX_rd       (MEMEX_rd),
        .MEMEX_rdval    (MEMEX_rdval),
        .MEMWB_ready    (MEMWB_ready),
        .MEMWB_rd       (MEMWB_rd),
        .MEMWB_val      (MEMWB_val),
        .misalign       (misalign)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        valid;
        logic        mem_active;
        logic        load;
        logic [1:0]  size;
        logic        uns;
        logic        hold;      // keep EXMEM_ready high while stalled
        logic [63:0] addr;
        logic [63:0] sdata;
        logic [63:0] rdata;
        logic [5:0]  rd;
        int          gnt_wait;  // cycles with gnt low in REQ
        int          rv_wait;   // cycles from gnt edge to rvalid edge (0 = same edge)
        logic        exp_mis;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
        logic        exp_ready;
        logic [5:0]  exp_rd;
        logic [63:0] exp_val;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    // ---------------- scoreboard ----------------
    logic [70:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        logic [70:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_queue: got empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_ready"}, 64'(MEMWB_ready), 64'(e[70]));
            chk({tag, "_rd"},    64'(MEMWB_rd),    64'(e[69:64]));
            chk({tag, "_val"},   MEMWB_val,        e[63:0]);
            chk({tag, "_fwdrd"}, 64'(MEMEX_rd),    64'(e[69:64]));
            chk({tag, "_fwdval"}, MEMEX_rdval,     e[63:0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        EXMEM_ready    = v.valid;
        exmm_aluresult = v.addr;
        dest_reg       = v.rd;
        mem_active     = v.mem_active;
        load           = v.load;
        mem_size       = v.size;
        mem_unsigned   = v.uns;
        store_data     = v.sdata;
        exp_q.push_back({v.exp_ready, v.exp_rd, v.exp_val});
        @(negedge clk);
        if (!v.hold) EXMEM_ready = 1'b0;
        if (!(v.valid && v.mem_active) || v.exp_mis) begin
            chk({tag, "_misalign"}, 64'(misalign), 64'(v.exp_mis));
            chk({tag, "_req"},      64'(dmem_req), 64'd0);
            chk({tag, "_stall"},    64'(MEMEX_stall), 64'd0);
            compare_out(tag);
            if (v.exp_mis) begin
                @(negedge clk);
                chk({tag, "_misalign_drop"}, 64'(misalign), 64'd0);
                chk({tag, "_req_after"},     64'(dmem_req), 64'd0);
            end
        end else begin
            chk({tag, "_stall"}, 64'(MEMEX_stall), 64'd1);
            chk({tag, "_req"},   64'(dmem_req), 64'd1);
            chk({tag, "_we"},    64'(dmem_we), 64'(!v.load));
            chk({tag, "_addr"},  dmem_addr, {v.addr[63:3], 3'b000});
            chk({tag, "_wstrb"}, 64'(dmem_wstrb), 64'(v.exp_wstrb));
            if (!v.load) chk({tag, "_wdata"}, dmem_wdata, v.exp_wdata);
            chk({tag, "_busy_ready"}, 64'(MEMWB_ready), 64'd0);
            for (int k = 0; k < v.gnt_wait; k++) begin
                @(negedge clk);
                chk({tag, "_wait_stall"}, 64'(MEMEX_stall), 64'd1);
                chk({tag, "_wait_req"},   64'(dmem_req), 64'd1);
                chk({tag, "_wait_addr"},  dmem_addr, {v.addr[63:3], 3'b000});
                chk({tag, "_wait_wstrb"}, 64'(dmem_wstrb), 64'(v.exp_wstrb));
            end
            dmem_gnt = 1'b1;
            if (v.load && v.rv_wait == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
            end
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = '0;
            if (v.load && v.rv_wait > 0) begin
                chk({tag, "_resp_req"},   64'(dmem_req), 64'd0);
                chk({tag, "_resp_stall"}, 64'(MEMEX_stall), 64'd1);
                chk({tag, "_resp_ready"}, 64'(MEMWB_ready), 64'd0);
                for (int k = 1; k < v.rv_wait; k++) begin
                    @(negedge clk);
                    chk({tag, "_resp_stall"}, 64'(MEMEX_stall), 64'd1);
                    chk({tag, "_resp_ready"}, 64'(MEMWB_ready), 64'd0);
                end
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                @(negedge clk);
                dmem_rvalid = 1'b0;
                dmem_rdata  = '0;
            end
            EXMEM_ready = 1'b0;
            chk({tag, "_done_stall"}, 64'(MEMEX_stall), 64'd0);
            compare_out(tag);
        end
        if (v.hold) begin
            @(negedge clk);
            chk({tag, "_not_consumed_ready"}, 64'(MEMWB_ready), 64'd0);
            chk({tag, "_not_consumed_req"},   64'(dmem_req), 64'd0);
        end
    endtask

    // ---------------- test ----------------
    initial begin
        reset = 1'b1;
        EXMEM_ready = 1'b0; exmm_aluresult = '0; dest_reg = '0; mem_active = 1'b0;
        load = 1'b0; mem_size = '0; mem_unsigned = 1'b0; store_data = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        //            vld   mact  load  size  uns   hold  addr                    sdata                   rdata                   rd     gw rw  mis   wstrb  wdata                   rdy   erd    eval
        vecs[0]  = '{1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,64'h1234,              64'h0,                  64'h0,                  6'd5,  0, 0, 1'b0,8'h00,64'h0,                  1'b1,6'd5, 64'h1234};
        vecs[1]  = '{1'b1,1'b0,1'b0,2'd3,1'b0,1'b0,64'hDEADBEEF_00000001,  64'h0,                  64'h0,                  6'd31, 0, 0, 1'b0,8'h00,64'h0,                  1'b1,6'd31,64'hDEADBEEF_00000001};
        vecs[2]  = '{1'b0,1'b1,1'b1,2'd1,1'b0,1'b0,64'h1001,              64'h0,                  64'h0,                  6'd3,  0, 0, 1'b0,8'h00,64'h0,                  1'b0,6'd0, 64'h0};
        vecs[3]  = '{1'b1,1'b1,1'b1,2'd0,1'b0,1'b0,64'h1003,              64'h0,                  64'h00000000_80000000,  6'd7,  0, 0, 1'b0,8'h00,64'h0,                  1'b1,6'd7, 64'hFFFFFFFF_FFFFFF80};
        vecs[4]  = '{1'b1,1'b1,1'b1,2'd0,1'b1,1'b0,64'h1003,              64'h0,                  64'h00000000_80000000,  6'd8,  0, 0, 1'b0,8'h00,64'h0,                  1'b1,6'd8, 64'h80};
        vecs[5]  = '{1'b1,1'b1,1'b0,2'd1,1'b0,1'b0,64'h1006,              64'hBEEF,               64'h0,                  6'd13, 3, 0, 1'b0,8'hC0,64'hBEEF0000_00000000,  1'b1,6'd0, 64'h0};
        vecs[6]  = '{1'b1,1'b1,1'b1,2'd2,1'b0,1'b0,64'h1002,              64'h0,                  64'h0,                  6'd14, 0, 0, 1'b1,8'h00,64'h0,                  1'b0,6'd0, 64'h0};
        vecs[7]  = '{1'b1,1'b1,1'b1,2'd3,1'b0,1'b1,64'h2000,              64'h0,                  64'h11223344_55667788,  6'd9,  0, 5, 1'b0,8'h00,64'h0,                  1'b1,6'd9, 64'h11223344_55667788};
        vecs[8]  = '{1'b1,1'b1,1'b1,2'd1,1'b0,1'b0,64'h100A,              64'h0,                  64'h00000000_80010000,  6'd10, 1, 2, 1'b0,8'h00,64'h0,                  1'b1,6'd10,64'hFFFFFFFF_FFFF8001};
        vecs[9]  = '{1'b1,1'b1,1'b1,2'd2,1'b1,1'b0,64'h1004,              64'h0,                  64'hF0E0D0C0_00000000,  6'd11, 0, 1, 1'b0,8'h00,64'h0,                  1'b1,6'd11,64'h00000000_F0E0D0C0};
        vecs[10] = '{1'b1,1'b1,1'b1,2'd2,1'b0,1'b0,64'h1004,              64'h0,                  64'hF0E0D0C0_00000000,  6'd12, 2, 1, 1'b0,8'h00,64'h0,                  1'b1,6'd12,64'hFFFFFFFF_F0E0D0C0};
        vecs[11] = '{1'b1,1'b1,1'b0,2'd3,1'b0,1'b0,64'h3008,              64'h01020304_05060708,  64'h0,                  6'd15, 1, 0, 1'b0,8'hFF,64'h01020304_05060708,  1'b1,6'd0, 64'h0};
        vecs[12] = '{1'b1,1'b1,1'b0,2'd0,1'b0,1'b0,64'h3005,              64'h12345678_9ABCDEAB,  64'h0,                  6'd16, 0, 0, 1'b0,8'h20,64'hBCDEAB00_00000000,  1'b1,6'd0, 64'h0};
        vecs[13] = '{1'b1,1'b1,1'b1,2'd3,1'b0,1'b0,64'h2004,              64'h0,                  64'h0,                  6'd17, 0, 0, 1'b1,8'h00,64'h0,                  1'b0,6'd0, 64'h0};
        vecs[14] = '{1'b1,1'b1,1'b1,2'd1,1'b1,1'b0,64'h1001,              64'h0,                  64'h0,                  6'd18, 0, 0, 1'b1,8'h00,64'h0,                  1'b0,6'd0, 64'h0};
        vecs[15] = '{1'b1,1'b1,1'b0,2'd2,1'b0,1'b0,64'h1004,              64'h11223344,           64'h0,                  6'd19, 0, 0, 1'b0,8'hF0,64'h11223344_00000000,  1'b1,6'd0, 64'h0};
        vecs[16] = '{1'b1,1'b1,1'b1,2'd1,1'b1,1'b0,64'h1002,              64'h0,                  64'h00000000_FFFF0000,  6'd20, 0, 0, 1'b0,8'h00,64'h0,                  1'b1,6'd20,64'h00000000_0000FFFF};
        vecs[17] = '{1'b1,1'b1,1'b1,2'd0,1'b0,1'b0,64'h1007,              64'h0,                  64'hA5000000_00000000,  6'd21, 0, 3, 1'b0,8'h00,64'h0,                  1'b1,6'd21,64'hFFFFFFFF_FFFFFFA5};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(MEMWB_ready), 64'd0);
        chk("rst_rd",    64'(MEMWB_rd), 64'd0);
        chk("rst_val",   MEMWB_val, 64'd0);
        chk("rst_req",   64'(dmem_req), 64'd0);
        chk("rst_wstrb", 64'(dmem_wstrb), 64'd0);
        chk("rst_stall", 64'(MEMEX_stall), 64'd0);
        chk("rst_mis",   64'(misalign), 64'd0);
        reset = 1'b0;

        // Grant/response strobes in IDLE must be ignored.
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFF;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk("idle_gnt_ready", 64'(MEMWB_ready), 64'd0);
        chk("idle_gnt_stall", 64'(MEMEX_stall), 64'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset while a load waits in RESP; a late rvalid must be dropped.
        @(negedge clk);
        EXMEM_ready = 1'b1; exmm_aluresult = 64'h2000; dest_reg = 6'd22;
        mem_active = 1'b1; load = 1'b1; mem_size = 2'd3; mem_unsigned = 1'b0;
        @(negedge clk);
        EXMEM_ready = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk("rr_resp_stall", 64'(MEMEX_stall), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rr_stall", 64'(MEMEX_stall), 64'd0);
        chk("rr_req",   64'(dmem_req), 64'd0);
        chk("rr_ready", 64'(MEMWB_ready), 64'd0);
        chk("rr_rd",    64'(MEMEX_rd), 64'd0);
        chk("rr_val",   MEMEX_rdval, 64'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'h11223344_55667788;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk("rr_stray_ready", 64'(MEMWB_ready), 64'd0);
        chk("rr_stray_val",   MEMWB_val, 64'd0);
        chk("rr_stray_stall", 64'(MEMEX_stall), 64'd0);

        // Stage still works after the mid-access reset.
        run_vec(vecs[0], 100);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
